anim_speed_ctrl: RTL and testbench

//   Control front-end of the seven-segment animation engine. Synchronises and debounces the four

---
 rtl/anim_speed_ctrl_pkg.sv | 12 +
 rtl/anim_speed_ctrl_debounce.sv | 54 +++++
 rtl/anim_speed_ctrl.sv | 117 +++++++++++
 tb/tb_anim_speed_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/anim_speed_ctrl_pkg.sv
// Shared definitions for the animation control front-end.
//   Button bit positions within btn_raw, used by the top level and by the
//   pattern datapath that consumes its outputs.
package anim_speed_ctrl_pkg;

  localparam int unsigned NUM_BTNS    = 4;
  localparam int unsigned BTN_INC_ANI = 0;
  localparam int unsigned BTN_DEC_ANI = 1;
  localparam int unsigned BTN_INC_SPD = 2;
  localparam int unsigned BTN_DEC_SPD = 3;

endpackage

// File: rtl/anim_speed_ctrl_debounce.sv
// btn_debounce: synchroniser, debouncer and press-pulse generator for one
// asynchronous, active-high push-button.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   ena    in  low: every register holds
//   raw    in  asynchronous button level
//   press  out one-cycle pulse on each debounced rising edge
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          db_state;
  logic          db_hist;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_state <= 1'b0;
      db_hist  <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else if (ena) begin
      sync1   <= raw;
      sync2   <= sync1;
      db_hist <= db_state;
      // Registered edge detect: keeps the event one cycle behind db_state.
      press   <= db_state & ~db_hist;
      if (sync2 != db_state) begin
        // This increment is the one that brings the count to DEBOUNCE_CYCLES.
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_state <= sync2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/anim_speed_ctrl.sv
// anim_speed_ctrl: control front-end of the seven-segment animation engine.
// Debounces the four push-buttons, keeps the animation index and speed level,
// and produces the frame-advance tick and frame counter.
//   clk           in  system clock (10 MHz nominal)
//   rst_n         in  synchronous active-low reset
//   ena           in  low: all state frozen, pulse outputs held low
//   btn_raw       in  [0]=incAni [1]=decAni [2]=incSpeed [3]=decSpeed
//   anim_idx      out current animation
//   speed         out current speed level (0 = slowest)
//   frame_idx     out current frame within the animation
//   frame_tick    out one-cycle pulse on each frame advance
//   anim_changed  out one-cycle pulse when anim_idx changes
module anim_speed_ctrl
  import anim_speed_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ANIM        = 8,
  parameter int unsigned NUM_FRAMES      = 8,
  parameter int unsigned MAX_SPEED       = 7,
  parameter int unsigned DEFAULT_SPEED   = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned BASE_TICKS      = 100000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic [3:0]                      btn_raw,
  output logic [$clog2(NUM_ANIM)-1:0]     anim_idx,
  output logic [$clog2(MAX_SPEED+1)-1:0]  speed,
  output logic [$clog2(NUM_FRAMES)-1:0]   frame_idx,
  output logic                            frame_tick,
  output logic                            anim_changed
);

  localparam int unsigned AW = $clog2(NUM_ANIM);
  localparam int unsigned SW = $clog2(MAX_SPEED + 1);
  localparam int unsigned FW = $clog2(NUM_FRAMES);
  localparam int unsigned TW = $clog2(BASE_TICKS * (MAX_SPEED + 1));

  logic [NUM_BTNS-1:0] press;
  logic                anim_inc;
  logic                anim_dec;
  logic                spd_inc;
  logic                spd_dec;
  logic [TW-1:0]       tick_cnt;
  logic [TW-1:0]       period_m1;
  logic                tick_hit;
  logic                tick_q;
  logic                anim_chg_q;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .raw   (btn_raw[i]),
      .press (press[i])
    );
  end

  always_comb begin
    anim_inc  = press[BTN_INC_ANI] & ~press[BTN_DEC_ANI];
    anim_dec  = press[BTN_DEC_ANI] & ~press[BTN_INC_ANI];
    // Events at saturation are dropped here so they cannot clear tick_cnt.
    spd_inc   = press[BTN_INC_SPD] & ~press[BTN_DEC_SPD] & (speed != SW'(MAX_SPEED));
    spd_dec   = press[BTN_DEC_SPD] & ~press[BTN_INC_SPD] & (speed != '0);
    period_m1 = TW'(BASE_TICKS * (MAX_SPEED + 1 - 32'(speed)) - 1);
    tick_hit  = (tick_cnt == period_m1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anim_idx   <= '0;
      speed      <= SW'(DEFAULT_SPEED);
      frame_idx  <= '0;
      tick_cnt   <= '0;
      tick_q     <= 1'b0;
      anim_chg_q <= 1'b0;
    end else if (ena) begin
      tick_q     <= 1'b0;
      anim_chg_q <= 1'b0;

      if (anim_inc) begin
        anim_idx <= (anim_idx == AW'(NUM_ANIM - 1)) ? '0 : anim_idx + 1'b1;
      end else if (anim_dec) begin
        anim_idx <= (anim_idx == '0) ? AW'(NUM_ANIM - 1) : anim_idx - 1'b1;
      end

      if (spd_inc) begin
        speed <= speed + 1'b1;
      end else if (spd_dec) begin
        speed <= speed - 1'b1;
      end

      // Counter restarts on any animation or speed change, pre-empting the tick.
      if (anim_inc || anim_dec) begin
        anim_chg_q <= 1'b1;
        frame_idx  <= '0;
        tick_cnt   <= '0;
      end else if (spd_inc || spd_dec) begin
        tick_cnt <= '0;
      end else if (tick_hit) begin
        tick_q    <= 1'b1;
        tick_cnt  <= '0;
        frame_idx <= (frame_idx == FW'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Pulses are masked while disabled so a frozen pulse register cannot leak out.
  assign frame_tick   = tick_q & ena;
  assign anim_changed = anim_chg_q & ena;

endmodule

// File: tb/tb_anim_speed_ctrl.sv
// Directed bench for anim_speed_ctrl with DEBOUNCE_CYCLES=4, BASE_TICKS=10.
module tb_anim_speed_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_raw;
  logic [2:0] anim_idx;
  logic [2:0] speed;
  logic [2:0] frame_idx;
  logic       frame_tick;
  logic       anim_changed;

  int n_checks = 0;
  int n_errors = 0;
  int chg_seen = 0;
  int tick_seen = 0;

  anim_speed_ctrl #(
    .NUM_ANIM        (8),
    .NUM_FRAMES      (8),
    .MAX_SPEED       (7),
    .DEFAULT_SPEED   (3),
    .DEBOUNCE_CYCLES (4),
    .BASE_TICKS      (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_raw      (btn_raw),
    .anim_idx     (anim_idx),
    .speed        (speed),
    .frame_idx    (frame_idx),
    .frame_tick   (frame_tick),
    .anim_changed (anim_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (anim_changed === 1'b1) chg_seen++;
    if (frame_tick === 1'b1) tick_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press_btn(input logic [3:0] mask);
    btn_raw = mask;
    repeat (20) @(negedge clk);
    btn_raw = '0;
    repeat (20) @(negedge clk);
  endtask

  // Cycles until the next frame_tick, -1 if none within the budget.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_tick !== 1'b1 && cycles < 300);
    if (frame_tick !== 1'b1) cycles = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_anim;
  int cyc;
  int fr;
  int ts;
  int cs;
  int spd_dec_exp[6] = '{2, 1, 0, 0, 0, 0};
  int spd_inc_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 7};

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    btn_raw = '0;

    // 1. reset state
    @(negedge clk);
    check("rst_anim", int'(anim_idx), 0);
    check("rst_speed", int'(speed), 3);
    check("rst_frame", int'(frame_idx), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_chg", int'(anim_changed), 0);
    rst_n = 1'b1;
    chg_seen = 0;

    // 2. ten clean incAni presses
    for (int i = 0; i < 10; i++) begin
      press_btn(4'b0001);
      check($sformatf("inc_anim_%0d", i), int'(anim_idx), (i + 1) % 8);
    end
    check("chg_pulses", chg_seen, 10);

    // 3. glitch of 3 cycles is ignored
    btn_raw = 4'b0001;
    repeat (3) @(negedge clk);
    btn_raw = '0;
    repeat (20) @(negedge clk);
    check("glitch_anim", int'(anim_idx), 2);
    check("glitch_chg", chg_seen, 10);

    // held 5 cycles: update lands exactly at edge N+7
    btn_raw = 4'b0001;
    repeat (5) @(negedge clk);
    btn_raw = '0;
    repeat (2) @(negedge clk);
    check("lat_before", int'(anim_idx), 2);
    @(negedge clk);
    check("lat_after", int'(anim_idx), 3);
    check("lat_pulse", int'(anim_changed), 1);
    check("lat_frame0", int'(frame_idx), 0);
    repeat (20) @(negedge clk);

    // 4. speed saturation and tick spacing
    do_reset();
    check("rst2_speed", int'(speed), 3);
    check("rst2_anim", int'(anim_idx), 0);
    for (int i = 0; i < 6; i++) begin
      press_btn(4'b1000);
      check($sformatf("dec_spd_%0d", i), int'(speed), spd_dec_exp[i]);
    end
    wait_tick(cyc);
    check("sync_tick_s0", (cyc > 0) ? 1 : 0, 1);
    fr = int'(frame_idx);
    wait_tick(cyc);
    check("period_s0", cyc, 80);
    check("frame_adv_s0", int'(frame_idx), (fr + 1) % 8);
    for (int i = 0; i < 8; i++) begin
      press_btn(4'b0100);
      check($sformatf("inc_spd_%0d", i), int'(speed), spd_inc_exp[i]);
    end
    wait_tick(cyc);
    check("sync_tick_s7", (cyc > 0) ? 1 : 0, 1);
    wait_tick(cyc);
    check("period_s7", cyc, 10);

    // 5. simultaneous events
    cs = chg_seen;
    press_btn(4'b0011);
    check("cancel_anim", int'(anim_idx), 0);
    check("cancel_chg", chg_seen, cs);
    press_btn(4'b1000);
    check("spd_to_6", int'(speed), 6);
    btn_raw = 4'b0101;
    repeat (7) @(negedge clk);
    check("both_anim_before", int'(anim_idx), 0);
    check("both_spd_before", int'(speed), 6);
    @(negedge clk);
    check("both_anim_after", int'(anim_idx), 1);
    check("both_spd_after", int'(speed), 7);
    btn_raw = '0;
    repeat (20) @(negedge clk);

    // 6. ena freeze mid-count (speed 7, period 10, frozen at tick_cnt=3)
    wait_tick(cyc);
    check("sync_tick_ena", (cyc > 0) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    fr = int'(frame_idx);
    ts = tick_seen;
    repeat (50) @(negedge clk);
    check("frozen_frame", int'(frame_idx), fr);
    check("frozen_ticks", tick_seen, ts);
    ena = 1'b1;
    wait_tick(cyc);
    check("resume_cycles", cyc, 7);
    check("resume_frame", int'(frame_idx), (fr + 1) % 8);

    // reset while incAni held
    btn_raw = 4'b0001;
    repeat (20) @(negedge clk);
    check("held_pre_rst", int'(anim_idx), 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("held_rst_anim", int'(anim_idx), 0);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("held_before", int'(anim_idx), 0);
    @(negedge clk);
    check("held_after", int'(anim_idx), 1);
    repeat (20) @(negedge clk);
    check("held_single", int'(anim_idx), 1);
    btn_raw = '0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
